// File: rtl/decoder_poly_writer_pkg.sv
// decoder_poly_writer_pkg: shared widths, Dilithium constants, encode modes and FSM states
package decoder_poly_writer_pkg;
  localparam int COEFF_W = 23;
  localparam int OUTPUT_W = 4;
  localparam int POLY_IDX_W = 3;
  localparam int WORD_IDX_W = 6;
  localparam int BEAT_W = OUTPUT_W * COEFF_W;
  localparam int ADDR_W = POLY_IDX_W + WORD_IDX_W;
  localparam int WORDS_PER_POLY = 64;
  localparam logic [COEFF_W-1:0] DILITHIUM_Q = 23'd8380417;
  localparam logic [3:0] K_LVL2 = 4'd4;
  localparam logic [3:0] K_LVL3 = 4'd6;
  localparam logic [3:0] K_LVL5 = 4'd8;
  localparam logic [3:0] L_LVL2 = 4'd4;
  localparam logic [3:0] L_LVL3 = 4'd5;
  localparam logic [3:0] L_LVL5 = 4'd7;
  typedef enum logic [2:0] {
    ENCODE_T0 = 3'd0,
    ENCODE_T1 = 3'd1,
    ENCODE_S1 = 3'd2,
    ENCODE_S2 = 3'd3,
    ENCODE_W1 = 3'd4,
    ENCODE_Z  = 3'd5
  } encode_e;
  typedef enum logic [1:0] {IDLE, RUN, LAST} state_e;
endpackage

// File: rtl/decoder_poly_writer_if.sv
// decoder_poly_writer_if: decoder beat stream in, polynomial RAM write port out
interface decoder_poly_writer_if;
  import decoder_poly_writer_pkg::*;
  logic [BEAT_W-1:0] samples;
  logic valid_i;
  logic ready_o;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [BEAT_W-1:0] wr_data;
  modport master (input samples, valid_i, output ready_o, wr_en, wr_addr, wr_data);
  modport slave (output samples, valid_i, input ready_o, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/decoder_poly_writer_poly_count.sv
// dpw_poly_count: decodes (sec_lvl, encode_mode) into polynomial count and legality
module dpw_poly_count
  import decoder_poly_writer_pkg::*;
(
  input  logic [2:0] sec_lvl,
  input  logic [2:0] encode_mode,
  output logic [3:0] n_poly,
  output logic       legal
);
  logic use_l;
  logic [3:0] k, l;
  always_comb begin
    use_l = encode_mode == ENCODE_S1 || encode_mode == ENCODE_Z;
    k = sec_lvl == 3'd2 ? K_LVL2 : sec_lvl == 3'd3 ? K_LVL3 : K_LVL5;
    l = sec_lvl == 3'd2 ? L_LVL2 : sec_lvl == 3'd3 ? L_LVL3 : L_LVL5;
    legal = sec_lvl inside {3'd2, 3'd3, 3'd5} && encode_mode <= ENCODE_Z;
    n_poly = legal ? (use_l ? l : k) : 4'd0;
  end
endmodule

// File: rtl/decoder_poly_writer.sv
// decoder_poly_writer: writes decoder beats into polynomial RAM; DECODER_POLY_WRITER_RANGE_CHECK_EN adds range_err
module decoder_poly_writer
  import decoder_poly_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] sec_lvl,
  input  logic [2:0] encode_mode,
  decoder_poly_writer_if.master bus,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
`ifdef DECODER_POLY_WRITER_RANGE_CHECK_EN
  ,
  output logic       range_err
`endif
);
  state_e state, state_n;
  logic [3:0] n_poly_cfg, n_poly;
  logic legal, go, accept, last_beat;
  logic [POLY_IDX_W-1:0] poly_idx;
  logic [WORD_IDX_W-1:0] word_idx;

  dpw_poly_count u_count (.sec_lvl(sec_lvl), .encode_mode(encode_mode), .n_poly(n_poly_cfg), .legal(legal));

  assign bus.ready_o = state == RUN;
  assign busy = state != IDLE;
  assign done = state == LAST;
  assign go = state == IDLE && start && !abort;
  assign accept = bus.valid_i && bus.ready_o && !abort;
  assign last_beat = word_idx == WORD_IDX_W'(WORDS_PER_POLY - 1) && {1'b0, poly_idx} == n_poly - 4'd1;

  always_comb begin
    state_n = abort ? IDLE :
              go && legal ? RUN :
              accept && last_beat ? LAST :
              state == LAST ? IDLE : state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      n_poly <= '0;
      poly_idx <= '0;
      word_idx <= '0;
      cfg_err <= 1'b0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      state <= state_n;
      cfg_err <= go && !legal;
      bus.wr_en <= accept;
      if (go && legal) begin
        n_poly <= n_poly_cfg;
        poly_idx <= '0;
        word_idx <= '0;
      end
      if (accept) begin
        bus.wr_addr <= {poly_idx, word_idx};
        bus.wr_data <= bus.samples;
        word_idx <= word_idx + 1'b1;
        if (&word_idx) poly_idx <= poly_idx + 1'b1;
      end
    end
  end

`ifdef DECODER_POLY_WRITER_RANGE_CHECK_EN
  logic over;
  always_comb begin
    over = 1'b0;
    for (int i = 0; i < OUTPUT_W; i++) over = over | (bus.samples[i*COEFF_W +: COEFF_W] >= DILITHIUM_Q);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) range_err <= 1'b0;
    else if (go) range_err <= 1'b0;
    else if (accept && over) range_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_decoder_poly_writer.sv
// tb_decoder_poly_writer: scoreboard bench for decoder_poly_writer
module tb_decoder_poly_writer;
  import decoder_poly_writer_pkg::*;
  typedef struct {
    int addr;
    logic [BEAT_W-1:0] data;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [2:0] sec_lvl = '0;
  logic [2:0] encode_mode = '0;
  logic busy, done, cfg_err;
`ifdef DECODER_POLY_WRITER_RANGE_CHECK_EN
  logic range_err;
`endif
  decoder_poly_writer_if bus ();

  decoder_poly_writer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sec_lvl(sec_lvl), .encode_mode(encode_mode), .bus(bus),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef DECODER_POLY_WRITER_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  bit m_run = 0;
  int m_addr = 0;
  int m_total = 0;
  int dones = 0;
  bit poison = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int tb_npoly(input int lvl, input int mode);
    bit use_l;
    use_l = mode == 2 || mode == 5;
    if (mode > 5 || !(lvl == 2 || lvl == 3 || lvl == 5)) return 0;
    return lvl == 2 ? 4 : lvl == 3 ? (use_l ? 5 : 6) : (use_l ? 7 : 8);
  endfunction

  function automatic logic [BEAT_W-1:0] rand_beat();
    logic [BEAT_W-1:0] b;
    for (int i = 0; i < OUTPUT_W; i++) b[i*COEFF_W +: COEFF_W] = COEFF_W'($urandom_range(0, int'(DILITHIUM_Q) - 1));
    return b;
  endfunction

  task automatic tick(input bit v, input bit ab = 1'b0, input bit st = 1'b0);
    exp_t e;
    bit acc, lastf;
    logic [BEAT_W-1:0] beat;
    beat = rand_beat();
    if (poison) beat[2*COEFF_W +: COEFF_W] = DILITHIUM_Q;
    acc = v && m_run && !ab;
    lastf = acc && m_addr == m_total - 1;
    bus.valid_i = v;
    bus.samples = beat;
    abort = ab;
    start = st;
    if (acc) begin
      e.addr = m_addr;
      e.data = beat;
      e.last = lastf;
      sb.push_back(e);
      m_addr++;
    end
    if (ab || lastf) m_run = 0;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    abort = 0;
    check("wr_en", bus.wr_en, acc);
    if (bus.wr_en && sb.size() > 0) begin
      e = sb.pop_front();
      check("wr_addr", bus.wr_addr, e.addr);
      check("wr_data", bus.wr_data, e.data);
    end
    check("done", done, lastf);
    check("ready_o", bus.ready_o, m_run);
    check("busy", busy, m_run || lastf);
    if (done) dones++;
  endtask

  task automatic do_start(input int lvl, input int mode, input bit ab = 1'b0);
    int np;
    np = tb_npoly(lvl, mode);
    sec_lvl = 3'(lvl);
    encode_mode = 3'(mode);
    bus.valid_i = 0;
    start = 1;
    abort = ab;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    abort = 0;
    m_run = np != 0 && !ab;
    m_total = np * WORDS_PER_POLY;
    m_addr = 0;
    dones = 0;
    sb.delete();
    check("cfg_err", cfg_err, np == 0 && !ab);
    check("busy_start", busy, m_run);
    check("wr_en_start", bus.wr_en, 1'b0);
  endtask

  task automatic run_vec(input int n_beats, input int gap_pct);
    while (m_run && m_addr < n_beats) tick($urandom_range(0, 99) >= gap_pct);
  endtask

  initial begin
    bus.valid_i = 0;
    bus.samples = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_ready", bus.ready_o, 1'b0);
    check("rst_wr_addr", bus.wr_addr, '0);
    rst = 1;
    @(negedge clk);
    check("idle_ready", bus.ready_o, 1'b0);

    do_start(2, 2);
    run_vec(256, 0);
    tick(0);
    check("done_cnt_s1", dones, 1);

    do_start(5, 3);
    run_vec(512, 30);
    tick(0);
    check("done_cnt_s2", dones, 1);

    do_start(3, 5);
    run_vec(10, 0);
    sec_lvl = 3'd5;
    tick(1, 0, 1);
    run_vec(320, 10);
    tick(0);
    check("done_cnt_z", dones, 1);
    check("addr_z_last", m_addr, 320);

    do_start(4, 2);
    tick(0);
    check("cfg_err_pulse", cfg_err, 1'b0);
    do_start(2, 6);
    tick(1);

    do_start(2, 0, 1);
    tick(1);

    do_start(3, 0);
    run_vec(100, 0);
    tick(1, 1);
    tick(1);
    check("done_cnt_abort", dones, 0);
    do_start(2, 1);
    run_vec(256, 20);
    tick(0);
    check("done_cnt_t1", dones, 1);

    do_start(2, 0);
    run_vec(50, 0);
    #2 rst = 0;
    #1;
    check("arst_wr_en", bus.wr_en, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", bus.ready_o, 1'b0);
    check("arst_wr_addr", bus.wr_addr, '0);
    @(negedge clk);
    rst = 1;
    m_run = 0;
    sb.delete();
    tick(1);
    tick(1);

`ifdef DECODER_POLY_WRITER_RANGE_CHECK_EN
    do_start(2, 0);
    check("range_clear0", range_err, 1'b0);
    tick(1);
    poison = 1;
    tick(1);
    poison = 0;
    tick(1);
    tick(0);
    check("range_set", range_err, 1'b1);
    do_start(2, 0);
    check("range_clear", range_err, 1'b0);
    tick(0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
